branch_resolve: RTL

- Consumer end of the ALU flag interface: holds the architectural V/Z/N flag register written by the execute stage.
- Tracks in-flight flag-writing instructions and stalls branches until their flags are architecturally final.
- Evaluates the 3-bit branch condition and hands the next PC to fetch over a valid/ready handshake.
- Sits between the execute stage (flag producer) and the fetch/PC logic.

---
 rtl/branch_resolve_pkg.sv | 24 ++
 rtl/branch_resolve_cond_eval.sv | 33 +++
 rtl/branch_resolve.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch_resolve: condition codes, flag bit positions and FSM encoding.
package branch_resolve_pkg;

    localparam logic [2:0] BR_NEQ    = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_GT     = 3'b010;
    localparam logic [2:0] BR_LT     = 3'b011;
    localparam logic [2:0] BR_GTE    = 3'b100;
    localparam logic [2:0] BR_LTE    = 3'b101;
    localparam logic [2:0] BR_OVFL   = 3'b110;
    localparam logic [2:0] BR_UNCOND = 3'b111;

    // Bit positions inside {V,Z,N}, matching the ALU flagsIn ordering
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2
    } brState_t;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Combinational branch condition evaluator: 3-bit condition code plus {V,Z,N} flags to taken.
module br_cond_eval
    import branch_resolve_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic flagV;
    logic flagZ;
    logic flagN;

    assign flagV = flags[FLAG_V];
    assign flagZ = flags[FLAG_Z];
    assign flagN = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_NEQ:    taken = !flagZ;
            BR_EQ:     taken = flagZ;
            BR_GT:     taken = !flagZ && !flagN;
            BR_LT:     taken = flagN;
            BR_GTE:    taken = flagZ || (!flagZ && !flagN);
            BR_LTE:    taken = flagN || flagZ;
            BR_OVFL:   taken = flagV;
            BR_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Flag register, in-flight flag-writer tracking and branch resolution with a valid/ready response.
// Define BR_FLAG_FWD_EN to let a branch leave WAIT in the same cycle as the final flag write.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int MAX_PEND = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_issue,
    input  logic            flag_we,
    input  logic [2:0]      flag_wmask,
    input  logic            V_in,
    input  logic            Z_in,
    input  logic            N_in,
    output logic [2:0]      flags_q,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] br_fall,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_taken,
    output logic [PC_W-1:0] resp_pc,
    input  logic            flush,
    output logic            pend_ovf
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic [2:0]      flagIn;
    logic [CNT_W-1:0] pendCnt;
    logic [CNT_W-1:0] pendNext;
    logic            pendDec;
    logic            pendSat;
    logic            idleClear;
    logic            waitClear;
    logic            accept;
    brState_t        stateReg;
    brState_t        stateNext;
    logic [2:0]      condReg;
    logic [PC_W-1:0] targetReg;
    logic [PC_W-1:0] fallReg;
    logic            takenLive;
    logic            takenHold;
    logic            evalHeld;
    logic            takenNow;

    assign flagIn = {V_in, Z_in, N_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flags_q[gi] <= 1'b0;
                end else if (flag_we && flag_wmask[gi]) begin
                    flags_q[gi] <= flagIn[gi];
                end
            end
        end
    endgenerate

    // A write with nothing pending is legal and must not wrap the counter
    always_comb begin
        pendDec  = flag_we && (pendCnt != '0);
        pendNext = pendCnt;
        pendSat  = 1'b0;
        if (flag_issue && !pendDec) begin
            if (pendCnt == CNT_W'(MAX_PEND)) begin
                pendSat = 1'b1;
            end else begin
                pendNext = pendCnt + 1'b1;
            end
        end else if (!flag_issue && pendDec) begin
            pendNext = pendCnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendCnt  <= '0;
            pend_ovf <= 1'b0;
        end else begin
            pendCnt <= pendNext;
            if (pendSat) begin
                pend_ovf <= 1'b1;
            end
        end
    end

    // An issue coinciding with the accept is older than the branch, so it must block
`ifdef BR_FLAG_FWD_EN
    assign idleClear = (pendNext == '0);
    assign waitClear = (pendNext == '0);
`else
    assign idleClear = (pendCnt == '0) && !flag_issue;
    assign waitClear = (pendCnt == '0);
`endif

    assign accept = (stateReg == ST_IDLE) && br_valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: if (br_valid) stateNext = idleClear ? ST_EVAL : ST_WAIT;
            ST_WAIT: if (waitClear) stateNext = ST_EVAL;
            ST_EVAL: if (resp_ready) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
        if (flush) begin
            stateNext = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            condReg   <= '0;
            targetReg <= '0;
            fallReg   <= '0;
        end else if (accept) begin
            condReg   <= br_cond;
            targetReg <= br_target;
            fallReg   <= br_fall;
        end
    end

    br_cond_eval u_cond_eval (
        .cond  (condReg),
        .flags (flags_q),
        .taken (takenLive)
    );

    // Freeze the decision after the first EVAL cycle so a stalled response cannot change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            takenHold <= 1'b0;
            evalHeld  <= 1'b0;
        end else begin
            evalHeld <= (stateReg == ST_EVAL) && (stateNext == ST_EVAL);
            if ((stateReg == ST_EVAL) && !evalHeld) begin
                takenHold <= takenLive;
            end
        end
    end

    assign takenNow = evalHeld ? takenHold : takenLive;

    always_comb begin
        br_ready   = 1'b0;
        resp_valid = 1'b0;
        resp_taken = 1'b0;
        resp_pc    = '0;
        case (stateReg)
            ST_IDLE: br_ready = 1'b1;
            ST_EVAL: begin
                resp_valid = 1'b1;
                resp_taken = takenNow;
                resp_pc    = takenNow ? targetReg : fallReg;
            end
            default: ;
        endcase
    end

endmodule
